// File: rtl/inst_fetch_pkg.sv
// Shared types and width constants for the instruction fetch slice.
package fetch_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned WORD_SIZE  = 32;
  localparam int unsigned BLOCK_SIZE = 128;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_RESP  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] pc;
    logic [INST_W-1:0]    inst;
  } fetch_entry_t;

  function automatic logic [WORD_SIZE-1:0] word_align(input logic [WORD_SIZE-1:0] a);
    return {a[WORD_SIZE-1:2], 2'b00};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Cache, redirect and decode-side signals of the fetch unit; master is the fetch unit.
interface inst_fetch_if;
  import fetch_pkg::*;

  logic [WORD_SIZE-1:0]  icache_addr;
  logic [BLOCK_SIZE-1:0] icache_block;
  logic                  icache_miss;
  logic                  redirect_valid;
  logic [WORD_SIZE-1:0]  redirect_pc;
  logic                  inst_valid;
  logic [INST_W-1:0]     inst_data;
  logic [WORD_SIZE-1:0]  inst_pc;
  logic                  inst_ready;

  modport master (
    output icache_addr,
    input  icache_block, icache_miss,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  icache_addr,
    output icache_block, icache_miss,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Instruction queue: wrapping-pointer FIFO with flush; head reads zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = WORD_SIZE + INST_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_MAX);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign count   = count_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding icache request, queue toward decode, redirect handling.
// Optional FETCH_STATS_EN adds saturating fetch / miss-cycle counters.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_miss_cycles,
`endif
  inst_fetch_if.master bus
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e         state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] drain_pc_q, drain_pc_d;
  logic                 push, pop, room;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  fetch_entry_t         push_entry, head_entry;

  assign pop  = bus.inst_valid && bus.inst_ready;
  // Room is judged after this cycle's pop so a full queue being drained can still issue.
  assign room = (fifo_count < CNT_W'(QUEUE_DEPTH)) || pop;

  assign push_entry.pc   = pc_q;
  assign push_entry.inst = bus.icache_block[BLOCK_SIZE-1 -: INST_W];

  assign bus.inst_valid = !fifo_empty;
  assign bus.inst_data  = head_entry.inst;
  assign bus.inst_pc    = head_entry.pc;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    drain_pc_d      = drain_pc_q;
    push            = 1'b0;
    bus.icache_addr = pc_q;
    unique case (state_q)
      S_ISSUE: begin
        if (!bus.redirect_valid && room) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.redirect_valid) begin
          if (bus.icache_miss) begin
            state_d    = S_DRAIN;
            drain_pc_d = pc_q;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (!bus.icache_miss) begin
          push    = 1'b1;
          pc_d    = pc_q + WORD_SIZE'(4);
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // The cache still works on the abandoned address; its response is dropped.
        bus.icache_addr = drain_pc_q;
        if (!bus.icache_miss) state_d = S_ISSUE;
      end
      default: state_d = S_ISSUE;
    endcase
    if (bus.redirect_valid) pc_d = word_align(bus.redirect_pc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ISSUE;
      pc_q       <= word_align(RESET_PC);
      drain_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drain_pc_q <= drain_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (WORD_SIZE + INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .data  (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head_entry)
  );

  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q, miss_cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q  <= '0;
      miss_cyc_q <= '0;
    end else begin
      if (push) fetched_q <= sat_inc(fetched_q);
      if ((state_q == S_RESP || state_q == S_DRAIN) && bus.icache_miss)
        miss_cyc_q <= sat_inc(miss_cyc_q);
    end
  end

  assign stat_fetched     = fetched_q;
  assign stat_miss_cycles = miss_cyc_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch (RESET_PC=0, QUEUE_DEPTH=4).
module tb_inst_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_miss_cycles;
`endif

  inst_fetch_if bus_if ();

  // Cache model: the instruction at address a is a ^ KEY.
  assign bus_if.icache_block = {bus_if.icache_addr ^ KEY, {(BLOCK_SIZE - 32){1'b0}}};

  inst_fetch #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
`ifdef FETCH_STATS_EN
    .stat_fetched     (stat_fetched),
    .stat_miss_cycles (stat_miss_cycles),
`endif
    .bus              (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n                 = 1'b0;
    bus_if.icache_miss    = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;
    bus_if.inst_ready     = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 64'(bus_if.inst_valid), 64'd1);
    chk({tag, "_pc"},    64'(bus_if.inst_pc), 64'(pc));
    chk({tag, "_data"},  64'(bus_if.inst_data), 64'(pc ^ KEY));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n                 = 1'b0;
    bus_if.icache_miss    = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;
    bus_if.inst_ready     = 1'b1;

    // Reset state
    tick();
    chk("rst_valid", 64'(bus_if.inst_valid), 64'd0);
    chk("rst_addr",  64'(bus_if.icache_addr), 64'd0);
    chk("rst_data",  64'(bus_if.inst_data), 64'd0);
    chk("rst_pc",    64'(bus_if.inst_pc), 64'd0);

    // Streaming, no misses: one push every second cycle
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stream_gap", 64'(bus_if.inst_valid), 64'd0);
      tick();
      chk_head("stream", 32'(4 * k));
    end

    // Five-cycle miss on the first request
    do_reset();
    bus_if.icache_miss = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      chk("miss_wait", {31'd0, bus_if.inst_valid, bus_if.icache_addr}, 64'd0);
    end
    bus_if.icache_miss = 1'b0;
    tick();
    chk_head("miss_first", 32'h0);
    tick();
    chk("miss_nodup", 64'(bus_if.inst_valid), 64'd0);
    tick();
    chk_head("miss_second", 32'h4);

    // Backpressure fills the queue, then drains in order
    do_reset();
    bus_if.inst_ready = 1'b0;
    repeat (14) tick();
    chk("full_addr", 64'(bus_if.icache_addr), 64'h10);
    chk_head("full_head", 32'h0);
    bus_if.inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("drain_order", {31'd0, bus_if.inst_valid, bus_if.inst_pc}, {31'd0, 1'b1, 32'(4 * i)});
      tick();
    end

    // Redirect with three entries queued
    do_reset();
    bus_if.inst_ready = 1'b0;
    repeat (6) tick();
    chk_head("redir_pre", 32'h0);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h0000_0103;
    tick();
    bus_if.redirect_valid = 1'b0;
    chk("redir_flush", 64'(bus_if.inst_valid), 64'd0);
    chk("redir_addr",  64'(bus_if.icache_addr), 64'h100);
    tick();
    tick();
    chk_head("redir_push", 32'h100);

    // Redirect during a four-cycle miss: stale block dropped
    do_reset();
    bus_if.icache_miss = 1'b1;
    tick();
    tick();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h0000_0200;
    tick();
    bus_if.redirect_valid = 1'b0;
    chk("drain_addr", 64'(bus_if.icache_addr), 64'h0);
    tick();
    tick();
    chk("drain_hold", {31'd0, bus_if.inst_valid, bus_if.icache_addr}, 64'd0);
    bus_if.icache_miss = 1'b0;
    tick();
    chk("drain_stale", 64'(bus_if.inst_valid), 64'd0);
    chk("drain_newpc", 64'(bus_if.icache_addr), 64'h200);
    tick();
    tick();
    chk_head("drain_push", 32'h200);

    // PC wrap and reset in the middle of a refill
    do_reset();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'hFFFF_FFFE;
    tick();
    bus_if.redirect_valid = 1'b0;
    tick();
    tick();
    chk_head("wrap_top", 32'hFFFF_FFFC);
    tick();
    tick();
    chk_head("wrap_zero", 32'h0);
    bus_if.inst_ready  = 1'b0;
    bus_if.icache_miss = 1'b1;
    tick();
    chk("midrst_pre", 64'(bus_if.icache_addr), 64'h4);
    rst_n = 1'b0;
    #1;
    chk("midrst_addr",  64'(bus_if.icache_addr), 64'h0);
    chk("midrst_valid", 64'(bus_if.inst_valid), 64'd0);
    tick();
    bus_if.icache_miss = 1'b0;
    bus_if.inst_ready  = 1'b1;
    rst_n = 1'b1;
    tick();
    tick();
    chk_head("midrst_first", 32'h0);

`ifdef FETCH_STATS_EN
    do_reset();
    chk("stat_rst", {stat_fetched, stat_miss_cycles}, 64'd0);
    bus_if.icache_miss = 1'b1;
    repeat (4) tick();
    bus_if.icache_miss = 1'b0;
    repeat (19) tick();
    chk("stat_fetched", 64'(stat_fetched), 64'd10);
    chk("stat_miss",    64'(stat_miss_cycles), 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-002 Parameter QUEUE_DEPTH, default 4; instruction queue entries, power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 icache_addr  output  WORD_SIZE  fetch byte address to the instruction cache.
REQ-006 icache_block  input  BLOCK_SIZE  cache block, left-aligned so the addressed byte is the MSB byte.
REQ-007 icache_miss  input  1  high while the cache is refilling; block not valid.
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_pc  input  WORD_SIZE  redirect target; bits [1:0] ignored.
REQ-010 inst_valid  output  1  queue head holds an instruction.
REQ-011 inst_data  output  32  instruction at queue head.
REQ-012 inst_pc  output  WORD_SIZE  address of inst_data.
REQ-013 inst_ready  input  1  decode accepts head; pop when inst_valid && inst_ready.

Function
REQ-014 The block SHALL implement FSM states S_ISSUE, S_RESP, S_DRAIN, with at most one cache request outstanding.
REQ-015 S_ISSUE: if queue count (after same-cycle pop) < QUEUE_DEPTH, drive icache_addr = pc and go S_RESP next edge; else stay, icache_addr held at pc.
REQ-016 S_RESP: icache_addr SHALL hold pc; while icache_miss=1 stay; when icache_miss=0 push {pc, icache_block[BLOCK_SIZE-1 -: 32]}, pc <= pc+4, go S_ISSUE.
REQ-017 Best-case throughput SHALL be one instruction per 2 cycles; each miss cycle adds exactly one cycle.
REQ-018 pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-019 pc[1:0] SHALL always be 0.
REQ-020 Queue SHALL be FIFO with wrapping read/write pointers and a count of width clog2(QUEUE_DEPTH)+1; push and pop in the same cycle SHALL both take effect.
REQ-021 inst_valid SHALL equal (count != 0); inst_data/inst_pc SHALL be the head entry combinationally.
REQ-022 Push SHALL never occur when full (guaranteed by REQ-015); pop when empty SHALL be ignored.
REQ-023 redirect_valid=1 at an edge: queue cleared (count=0, pointers 0), pc <= {redirect_pc[31:2],2'b00}; any same-cycle push and pop discarded.
REQ-024 Redirect in S_ISSUE, or in S_RESP with icache_miss=0: next state S_ISSUE.
REQ-025 Redirect in S_RESP with icache_miss=1: next state S_DRAIN; S_DRAIN SHALL keep icache_addr at the old request address until icache_miss=0, discard that response, then go S_ISSUE with the new pc.
REQ-026 Redirect in S_DRAIN SHALL update pc only; S_DRAIN continues.

Reset
REQ-027 rst_n low SHALL immediately force: state S_ISSUE, pc RESET_PC, queue empty, inst_valid 0, icache_addr RESET_PC.
REQ-028 Reset mid-refill SHALL abandon the request; first post-reset push is from RESET_PC.
REQ-029 inst_data and inst_pc SHALL read 0 while the queue is empty after reset.

Configuration
REQ-030 With FETCH_STATS_EN defined: outputs stat_fetched[31:0] (pushes) and stat_miss_cycles[31:0] (cycles in S_RESP/S_DRAIN with icache_miss=1), both saturating at 32'hFFFF_FFFF, cleared by reset.
REQ-031 Without FETCH_STATS_EN: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package fetch_pkg: FSM state enum, INST_W=32, width constants mirroring WORD_SIZE/BLOCK_SIZE.
REQ-033 Queue SHALL be sub-module fetch_fifo (parameter DEPTH, WIDTH=WORD_SIZE+32; ports push, pop, flush, full, empty, count, head).

Verification
REQ-034 Reset, RESET_PC=0, no misses, inst_ready=1 -> pushes at pc 0,4,8 on every second cycle; first inst_valid 2 cycles after reset release.
REQ-035 icache_miss high 5 cycles on first request -> first push 7 cycles after reset release, pc=0, no duplicate entry.
REQ-036 inst_ready=0, QUEUE_DEPTH=4 -> exactly 4 entries (pc 0..12), then icache_addr holds 16, no further pushes; inst_ready=1 resumes in order.
REQ-037 Redirect to 32'h0000_0103 with 3 entries queued -> next cycle inst_valid=0; next push inst_pc=32'h0000_0100.
REQ-038 Redirect to 32'h200 during 4-cycle miss -> stale block discarded; first push inst_pc=32'h200.
REQ-039 FETCH_STATS_EN defined, 10 fetches with 3 miss cycles total -> stat_fetched=10, stat_miss_cycles=3.
